// File: rtl/dct_frame_sequencer.sv
// Frame sequencer for the 8-point DCT: gathers 8 samples, launches the core, waits its
// fixed latency, then streams the 8 coefficients out. Optional shadow buffer: DCT_SEQ_OVERLAP_EN.
module dct_frame_sequencer #(
    parameter int DATA_W       = 12,
    parameter int COEF_W       = 12,
    parameter int N            = 8,
    parameter int CORE_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic [N*DATA_W-1:0] core_x,
    output logic                core_start,
    input  logic [N*COEF_W-1:0] core_z,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [COEF_W-1:0]   out_data,
    output logic [2:0]          out_idx,
    output logic                out_last,
    output logic                frame_done
);
    typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT, DRAIN} state_t;

    state_t                   state_q;
    logic [2:0]               wr_idx_q, rd_idx_q, out_idx_q;
    logic [7:0]               lat_cnt_q;
    logic                     in_ready_q, core_start_q, out_valid_q, out_last_q, frame_done_q;
    logic [N*DATA_W-1:0]      core_x_q;
    logic [COEF_W-1:0]        out_data_q;
    logic signed [DATA_W-1:0] samp_q [N];
    logic signed [COEF_W-1:0] coef_q [N];
    logic [N*DATA_W-1:0]      frame_w;
    logic                     in_hs, out_hs, out_end, capture;

    assign in_hs   = in_valid && in_ready_q;
    assign out_hs  = out_valid_q && out_ready;
    assign out_end = (state_q == DRAIN) && out_hs && (rd_idx_q == 3'd7);
    assign capture = ((state_q == LAUNCH) && (CORE_LATENCY == 0)) ||
                     ((state_q == WAIT) && (lat_cnt_q == 8'd0));

    // Collect buffer as it looks once the incoming sample lands in the last slot
    always_comb begin
        frame_w = '0;
        for (int i = 0; i < N; i++) frame_w[i*DATA_W +: DATA_W] = samp_q[i];
        frame_w[(N-1)*DATA_W +: DATA_W] = in_data;
    end

`ifdef DCT_SEQ_OVERLAP_EN
    logic signed [DATA_W-1:0] shad_q [N];
    logic [3:0]               shad_cnt_q, shad_cnt_w;
    logic                     shad_hs;
    logic [N*DATA_W-1:0]      shad_frame_w;

    assign shad_hs    = in_hs && (state_q != COLLECT);
    assign shad_cnt_w = shad_cnt_q + {3'd0, shad_hs};

    // Shadow contents including a sample accepted in this same cycle
    always_comb begin
        shad_frame_w = '0;
        for (int i = 0; i < N; i++)
            shad_frame_w[i*DATA_W +: DATA_W] =
                (shad_hs && (shad_cnt_q[2:0] == 3'(i))) ? in_data : shad_q[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            wr_idx_q     <= 3'd0;
            rd_idx_q     <= 3'd0;
            lat_cnt_q    <= 8'd0;
            in_ready_q   <= 1'b1;
            core_start_q <= 1'b0;
            core_x_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_idx_q    <= 3'd0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef DCT_SEQ_OVERLAP_EN
            shad_cnt_q   <= 4'd0;
`endif
        end else begin
            core_start_q <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef DCT_SEQ_OVERLAP_EN
            if (shad_hs) begin
                shad_q[shad_cnt_q[2:0]] <= in_data;
                shad_cnt_q              <= shad_cnt_w;
                in_ready_q              <= (shad_cnt_w != 4'd8);
            end
`endif
            case (state_q)
                COLLECT: if (in_hs) begin
                    samp_q[wr_idx_q] <= in_data;
                    wr_idx_q         <= wr_idx_q + 3'd1;
                    if (wr_idx_q == 3'd7) begin
                        state_q      <= LAUNCH;
                        core_start_q <= 1'b1;
                        core_x_q     <= frame_w;
`ifndef DCT_SEQ_OVERLAP_EN
                        in_ready_q   <= 1'b0;
`endif
                    end
                end
                LAUNCH: if (CORE_LATENCY != 0) begin
                    lat_cnt_q <= 8'(CORE_LATENCY - 1);
                    state_q   <= WAIT;
                end
                WAIT: if (lat_cnt_q != 8'd0) lat_cnt_q <= lat_cnt_q - 8'd1;
                DRAIN: if (out_hs) begin
                    rd_idx_q   <= rd_idx_q + 3'd1;
                    out_data_q <= coef_q[rd_idx_q + 3'd1];
                    out_idx_q  <= rd_idx_q + 3'd1;
                    out_last_q <= (rd_idx_q == 3'd6);
                end
                default: state_q <= COLLECT;
            endcase

            if (capture) begin
                for (int i = 0; i < N; i++) coef_q[i] <= core_z[i*COEF_W +: COEF_W];
                state_q     <= DRAIN;
                out_valid_q <= 1'b1;
                out_data_q  <= core_z[COEF_W-1:0];
                out_idx_q   <= 3'd0;
                out_last_q  <= 1'b0;
            end

            if (out_end) begin
                out_valid_q  <= 1'b0;
                out_last_q   <= 1'b0;
                frame_done_q <= 1'b1;
                in_ready_q   <= 1'b1;
`ifdef DCT_SEQ_OVERLAP_EN
                shad_cnt_q   <= 4'd0;
                if (shad_cnt_w == 4'd8) begin
                    state_q      <= LAUNCH;
                    core_start_q <= 1'b1;
                    core_x_q     <= shad_frame_w;
                end else begin
                    // Partial shadow frame continues filling in COLLECT
                    state_q  <= COLLECT;
                    wr_idx_q <= shad_cnt_w[2:0];
                    for (int i = 0; i < N; i++) samp_q[i] <= shad_frame_w[i*DATA_W +: DATA_W];
                end
`else
                state_q      <= COLLECT;
`endif
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign core_x     = core_x_q;
    assign core_start = core_start_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_idx    = out_idx_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
endmodule
